// File: rtl/clk_fwd_ddr_multi.sv
// Multi-channel forwarded-clock generator with lock/settle sequencer and glitch-free dividers.
// Optional CLK_FWD_INVERT_EN adds a per-channel inv_mask input; the ODDR+OBUFDS pair is modelled.
module clk_fwd_ddr_multi #(
    parameter int unsigned NCH           = 4,
    parameter int unsigned DIV_W         = 8,
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 locked,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH*DIV_W-1:0] div_sel,
`ifdef CLK_FWD_INVERT_EN
    input  logic [NCH-1:0]       inv_mask,
`endif
    output logic [NCH-1:0]       clk_out_p,
    output logic [NCH-1:0]       clk_out_n,
    output logic                 ready,
    output logic [NCH-1:0]       ch_active
);

    localparam int unsigned SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StWaitLock,
        StSettle,
        StRun
    } seq_state_e;

    seq_state_e        r_state;
    seq_state_e        w_state_nx;
    logic [SCNT_W-1:0] r_scnt;
    logic [SCNT_W-1:0] w_scnt_nx;
    logic              w_run;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= StWaitLock;
            r_scnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_scnt  <= w_scnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_scnt_nx  = r_scnt;
        unique case (r_state)
            StWaitLock: begin
                w_scnt_nx = '0;
                if (locked) w_state_nx = StSettle;
            end
            StSettle: begin
                if (!locked) begin
                    w_state_nx = StWaitLock;
                    w_scnt_nx  = '0;
                end else if (r_scnt == SCNT_LAST) begin
                    w_state_nx = StRun;
                    w_scnt_nx  = '0;
                end else begin
                    w_scnt_nx = r_scnt + 1'b1;
                end
            end
            StRun: begin
                if (!locked) w_state_nx = StWaitLock;
            end
            default: w_state_nx = StWaitLock;
        endcase
    end

    assign ready = (r_state == StRun);
    // Losing lock parks every channel on the same edge the sequencer leaves RUN.
    assign w_run = (r_state == StRun) && locked;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic             r_act, r_lvl, r_d1, r_d2, r_q1, r_q2;
        logic [DIV_W-1:0] r_cnt, r_div;
        logic             w_act_nx, w_lvl_nx, w_d1_nx, w_d2_nx, w_inv_nx, w_pin;
        logic [DIV_W-1:0] w_cnt_nx, w_div_nx, w_div_in, w_last;

        assign w_div_in = div_sel[g*DIV_W +: DIV_W];
        assign w_last   = r_div - 1'b1;

        always_comb begin
            w_act_nx = r_act;
            w_lvl_nx = r_lvl;
            w_cnt_nx = r_cnt;
            w_div_nx = r_div;
            if (!w_run) begin
                w_act_nx = 1'b0;
                w_lvl_nx = 1'b0;
                w_cnt_nx = '0;
                if (!r_act) w_div_nx = w_div_in;
            end else if (!r_act) begin
                w_div_nx = w_div_in;
                if (ch_en[g]) begin
                    w_act_nx = 1'b1;
                    w_lvl_nx = (w_div_in != '0);
                    w_cnt_nx = '0;
                end
            end else if (r_div == '0) begin
                // Full rate: every cycle is a period boundary.
                if (!ch_en[g]) begin
                    w_act_nx = 1'b0;
                end else begin
                    w_div_nx = w_div_in;
                    w_lvl_nx = (w_div_in != '0);
                    w_cnt_nx = '0;
                end
            end else if (r_cnt != w_last) begin
                w_cnt_nx = r_cnt + 1'b1;
            end else if (r_lvl) begin
                w_lvl_nx = 1'b0;
                w_cnt_nx = '0;
                if (!ch_en[g]) w_act_nx = 1'b0;
            end else begin
                w_div_nx = w_div_in;
                w_lvl_nx = (w_div_in != '0);
                w_cnt_nx = '0;
            end
        end

`ifdef CLK_FWD_INVERT_EN
        logic r_inv;
        assign w_inv_nx = r_act ? r_inv : inv_mask[g];
        always_ff @(posedge clk_in) begin
            if (rst) r_inv <= 1'b0;
            else     r_inv <= w_inv_nx;
        end
`else
        assign w_inv_nx = 1'b0;
`endif

        always_comb begin
            w_d1_nx = w_inv_nx;
            w_d2_nx = w_inv_nx;
            if (w_act_nx) begin
                if (w_div_nx == '0) begin
                    w_d1_nx = ~w_inv_nx;
                    w_d2_nx = w_inv_nx;
                end else begin
                    w_d1_nx = w_lvl_nx ^ w_inv_nx;
                    w_d2_nx = w_lvl_nx ^ w_inv_nx;
                end
            end
        end

        always_ff @(posedge clk_in) begin
            if (rst) begin
                r_act <= 1'b0;
                r_lvl <= 1'b0;
                r_cnt <= '0;
                r_div <= '0;
                r_d1  <= 1'b0;
                r_d2  <= 1'b0;
            end else begin
                r_act <= w_act_nx;
                r_lvl <= w_lvl_nx;
                r_cnt <= w_cnt_nx;
                r_div <= w_div_nx;
                r_d1  <= w_d1_nx;
                r_d2  <= w_d2_nx;
            end
        end

        // SAME_EDGE ODDR: D1 drives the high phase, D2 the low phase, one cycle after capture.
        always_ff @(posedge clk_in) begin
            r_q1 <= r_d1;
            r_q2 <= r_d2;
        end

        assign w_pin        = clk_in ? r_q1 : r_q2;
        assign clk_out_p[g] = w_pin;
        assign clk_out_n[g] = ~w_pin;
        assign ch_active[g] = r_act;
    end

endmodule

// File: tb/tb_clk_fwd_ddr_multi.sv
// Bench for clk_fwd_ddr_multi: vector table plus hand sequences; pin expectations go through a
// one-deep scoreboard queue to cover the ODDR latency. Define CLK_FWD_INVERT_EN for inv_mask.
module tb_clk_fwd_ddr_multi;

    localparam int unsigned NCH    = 4;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned SETTLE = 16;

    logic                 clk_in = 1'b0;
    logic                 rst;
    logic                 locked;
    logic [NCH-1:0]       ch_en;
    logic [NCH*DIV_W-1:0] div_sel;
    logic [NCH-1:0]       inv_mask;
    logic [NCH-1:0]       clk_out_p;
    logic [NCH-1:0]       clk_out_n;
    logic                 ready;
    logic [NCH-1:0]       ch_active;

    always #5 clk_in = ~clk_in;

    clk_fwd_ddr_multi #(
        .NCH           (NCH),
        .DIV_W         (DIV_W),
        .SETTLE_CYCLES (SETTLE)
    ) u_dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .locked    (locked),
        .ch_en     (ch_en),
        .div_sel   (div_sel),
`ifdef CLK_FWD_INVERT_EN
        .inv_mask  (inv_mask),
`endif
        .clk_out_p (clk_out_p),
        .clk_out_n (clk_out_n),
        .ready     (ready),
        .ch_active (ch_active)
    );

    typedef struct {
        logic [NCH-1:0] hi;
        logic [NCH-1:0] lo;
        logic           en;
    } pin_t;

    typedef struct {
        logic                 rs;
        logic                 lk;
        logic [NCH-1:0]       en;
        logic [NCH*DIV_W-1:0] div;
        logic                 rdy;
        logic [NCH-1:0]       act;
        logic [NCH-1:0]       hi;
        logic [NCH-1:0]       lo;
    } vec_t;

    pin_t           pin_q[$];
    vec_t           tbl[$];
    int             checks = 0;
    int             errors = 0;
    logic [NCH-1:0] s_phi, s_plo, s_nhi, s_nlo;

    function automatic logic [NCH*DIV_W-1:0] dv(input int d0, input int d1, input int d2,
                                                input int d3);
        logic [NCH*DIV_W-1:0] r;
        r = '0;
        r[0*DIV_W +: DIV_W] = DIV_W'(d0);
        r[1*DIV_W +: DIV_W] = DIV_W'(d1);
        r[2*DIV_W +: DIV_W] = DIV_W'(d2);
        r[3*DIV_W +: DIV_W] = DIV_W'(d3);
        return r;
    endfunction

    function automatic void add(input logic rs, input logic lk, input logic [NCH-1:0] en,
                                input logic [NCH*DIV_W-1:0] div, input logic rdy,
                                input logic [NCH-1:0] act, input logic [NCH-1:0] hi,
                                input logic [NCH-1:0] lo);
        vec_t v;
        v.rs = rs; v.lk = lk; v.en = en; v.div = div;
        v.rdy = rdy; v.act = act; v.hi = hi; v.lo = lo;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string tag, input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s got %0h want %0h at %0t", tag, name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
        s_phi = clk_out_p;
        s_nhi = clk_out_n;
        @(negedge clk_in);
        #2;
        s_plo = clk_out_p;
        s_nlo = clk_out_n;
    endtask

    // hi/lo are the D1/D2 levels this edge should register; they reach the pins one cycle later.
    task automatic step(input string tag, input logic rs, input logic lk,
                        input logic [NCH-1:0] en, input logic [NCH*DIV_W-1:0] div,
                        input logic rdy, input logic [NCH-1:0] act,
                        input logic [NCH-1:0] hi, input logic [NCH-1:0] lo);
        pin_t           e;
        logic [NCH-1:0] inv_hi, inv_lo;
        rst     = rs;
        locked  = lk;
        ch_en   = en;
        div_sel = div;
        e.hi = hi; e.lo = lo; e.en = 1'b1;
        pin_q.push_back(e);
        tick();
        chk(tag, "ready", 32'(ready), 32'(rdy));
        chk(tag, "ch_active", 32'(ch_active), 32'(act));
        if (pin_q.size() < 2) begin
            chk(tag, "scoreboard_depth", 32'(pin_q.size()), 32'd2);
        end else begin
            e = pin_q.pop_front();
            if (e.en) begin
                inv_hi = ~e.hi;
                inv_lo = ~e.lo;
                chk(tag, "p_high_phase", 32'(s_phi), 32'(e.hi));
                chk(tag, "p_low_phase", 32'(s_plo), 32'(e.lo));
                chk(tag, "n_high_phase", 32'(s_nhi), 32'(inv_hi));
                chk(tag, "n_low_phase", 32'(s_nlo), 32'(inv_lo));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pin_t           p0;
        logic [19:0]    pat;
        logic [19:0]    act1;
        logic [9:0]     c_hi, c_lo, c_act;
        logic [NCH-1:0] b;

        // Sequencer: locked for 11 cycles, glitch low, then a clean 16-cycle settle.
        for (int i = 0; i < 11; i++) add(0, 1, '0, '0, 0, '0, '0, '0);
        add(0, 0, '0, '0, 0, '0, '0, '0);
        for (int i = 0; i < 17; i++) add(0, 1, '0, '0, (i == 16), '0, '0, '0);
        // Channel 0 full rate, then immediate turn-off.
        for (int i = 0; i < 4; i++) add(0, 1, 4'b0001, '0, 1, 4'b0001, 4'b0001, 4'b0000);
        add(0, 1, '0, '0, 1, '0, '0, '0);
        // Channel 1 div 3, changed to 5 mid-high, back to 3, then disabled at cnt 0 of high.
        pat  = 20'b11100011111000001110;
        act1 = 20'b11111111111111111110;
        for (int i = 0; i < 20; i++) begin
            b = {2'b00, pat[19-i], 1'b0};
            add(0, 1, (i < 17) ? 4'b0010 : 4'b0000,
                dv(0, (i == 0 || i >= 13) ? 3 : 5, 0, 0),
                1, {2'b00, act1[19-i], 1'b0}, b, b);
        end
        add(0, 1, '0, '0, 1, '0, '0, '0);
        add(0, 1, '0, '0, 1, '0, '0, '0);
        // All channels running (0,3,2,1), lose lock, resettle, rerun, then reset mid-period.
        add(0, 1, 4'b1111, dv(0, 3, 2, 1), 1, 4'b1111, 4'b1111, 4'b1110);
        add(0, 1, 4'b1111, dv(0, 3, 2, 1), 1, 4'b1111, 4'b0111, 4'b0110);
        add(0, 1, 4'b1111, dv(0, 3, 2, 1), 1, 4'b1111, 4'b1011, 4'b1010);
        add(0, 1, 4'b1111, dv(0, 3, 2, 1), 1, 4'b1111, 4'b0001, 4'b0000);
        add(0, 1, 4'b1111, dv(0, 3, 2, 1), 1, 4'b1111, 4'b1101, 4'b1100);
        add(0, 1, 4'b1111, dv(0, 3, 2, 1), 1, 4'b1111, 4'b0101, 4'b0100);
        add(0, 0, 4'b1111, dv(0, 3, 2, 1), 0, '0, '0, '0);
        for (int i = 0; i < 17; i++) add(0, 1, 4'b1111, dv(0, 3, 2, 1), (i == 16), '0, '0, '0);
        add(0, 1, 4'b1111, dv(0, 3, 2, 1), 1, 4'b1111, 4'b1111, 4'b1110);
        add(0, 1, 4'b1111, dv(0, 3, 2, 1), 1, 4'b1111, 4'b0111, 4'b0110);
        add(1, 1, 4'b1111, dv(0, 3, 2, 1), 0, '0, '0, '0);
        add(0, 0, '0, '0, 0, '0, '0, '0);

        inv_mask = '0;
        p0.hi = '0; p0.lo = '0; p0.en = 1'b0;
        pin_q.push_back(p0);
        for (int i = 0; i < 3; i++) step("reset", 1, 0, '0, '0, 0, '0, '0, '0);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].rs, tbl[i].lk, tbl[i].en, tbl[i].div,
                 tbl[i].rdy, tbl[i].act, tbl[i].hi, tbl[i].lo);
        end

        for (int i = 0; i < 17; i++) step("resettle", 0, 1, '0, '0, (i == 16), '0, '0, '0);

        // Channel 2: div 2 -> 1 at a period start, 0 requested mid-high, then full rate and off.
        c_hi  = 10'b1100101010;
        c_lo  = 10'b1100101000;
        c_act = 10'b1111111110;
        for (int i = 0; i < 10; i++) begin
            step("div_switch", 0, 1, (i < 9) ? 4'b0100 : 4'b0000,
                 dv(0, 0, (i < 4) ? 2 : ((i < 7) ? 1 : 0), 0), 1,
                 {1'b0, c_act[9-i], 2'b00}, {1'b0, c_hi[9-i], 2'b00}, {1'b0, c_lo[9-i], 2'b00});
        end
        step("div_switch", 0, 1, '0, '0, 1, '0, '0, '0);

`ifdef CLK_FWD_INVERT_EN
        inv_mask = 4'b0100;
        step("inv_park", 0, 1, '0, '0, 1, '0, 4'b0100, 4'b0100);
        step("inv_run", 0, 1, 4'b0100, '0, 1, 4'b0100, 4'b0000, 4'b0100);
        inv_mask = 4'b0000;
        step("inv_hold", 0, 1, 4'b0100, '0, 1, 4'b0100, 4'b0000, 4'b0100);
        step("inv_off", 0, 1, '0, '0, 1, '0, 4'b0100, 4'b0100);
        step("inv_clear", 0, 1, '0, '0, 1, '0, '0, '0);
`endif
        step("flush", 0, 1, '0, '0, 1, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
